control_sequencer_module: RTL and testbench

Microcoded control sequencer for the 8-bit bus CPU. It steps through a fetch/execute T-state cycle and drives the `ie`/`oe`/`step` strobes of every bus register: program counter, MAR, RAM, IR, A, B, ALU, flags and output register. It is the initiator side of the shared-bus register protocol. It decides each cycle which single unit drives the bus and which units load from it.

---
 rtl/control_sequencer_module_if.sv | 36 +++
 rtl/control_sequencer_module.sv | 164 ++++++++++++++++
 tb/tb_control_sequencer_module.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_module_if.sv
// Shared-bus control strobes between the microcoded sequencer (master) and the
// datapath registers (slave), plus the opcode/flag inputs the sequencer decodes.
interface control_sequencer_module_if;
  logic [3:0] opcode;
  logic       carry;
  logic       zero;
  logic       pc_oe;
  logic       pc_ie;
  logic       pc_step;
  logic       mar_ie;
  logic       ram_oe;
  logic       ram_ie;
  logic       ir_ie;
  logic       ir_oe;
  logic       a_ie;
  logic       a_oe;
  logic       b_ie;
  logic       alu_oe;
  logic       alu_sub;
  logic       flags_ie;
  logic       out_ie;
  logic       hlt;
  logic [2:0] tstate;

  modport master (
    input  opcode, carry, zero,
    output pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, hlt, tstate
  );

  modport slave (
    output opcode, carry, zero,
    input  pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, hlt, tstate
  );
endinterface

// File: rtl/control_sequencer_module.sv
// Fetch/execute T-state sequencer for the 8-bit bus CPU: decodes T-state, opcode
// and flags into the per-cycle bus drive/load strobes, with a sticky halt.
module control_sequencer_module (
  input  logic                         clk,
  input  logic                         rst,
  control_sequencer_module_if.master   bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  tstate_e tstate_q, tstate_d;
  logic    halted_q, halted_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tstate_q <= T0;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

  // Each instruction returns to T0 right after its last step; HLT parks in T2.
  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (tstate_q)
        T0: tstate_d = T1;
        T1: tstate_d = T2;
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: tstate_d = T3;
            OP_HLT: begin
              tstate_d = T2;
              halted_d = 1'b1;
            end
            default: tstate_d = T0;
          endcase
        end
        T3: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) tstate_d = T4;
          else tstate_d = T0;
        end
        default: tstate_d = T0;
      endcase
    end
  end

  assign bus.tstate = tstate_q;

  // hlt is raised already in the T2 that sets the sticky bit, so the halt is visible from T2 on.
  always_comb begin
    bus.pc_oe    = 1'b0;
    bus.pc_ie    = 1'b0;
    bus.pc_step  = 1'b0;
    bus.mar_ie   = 1'b0;
    bus.ram_oe   = 1'b0;
    bus.ram_ie   = 1'b0;
    bus.ir_ie    = 1'b0;
    bus.ir_oe    = 1'b0;
    bus.a_ie     = 1'b0;
    bus.a_oe     = 1'b0;
    bus.b_ie     = 1'b0;
    bus.alu_oe   = 1'b0;
    bus.alu_sub  = 1'b0;
    bus.flags_ie = 1'b0;
    bus.out_ie   = 1'b0;
    bus.hlt      = 1'b0;
    if (rst) begin
      bus.hlt = 1'b0;
    end else if (halted_q) begin
      bus.hlt = 1'b1;
    end else begin
      case (tstate_q)
        T0: begin
          bus.pc_oe  = 1'b1;
          bus.mar_ie = 1'b1;
        end
        T1: begin
          bus.ram_oe  = 1'b1;
          bus.ir_ie   = 1'b1;
          bus.pc_step = 1'b1;
        end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.ir_oe  = 1'b1;
              bus.mar_ie = 1'b1;
            end
            OP_LDI: begin
              bus.ir_oe = 1'b1;
              bus.a_ie  = 1'b1;
            end
            OP_JMP: begin
              bus.ir_oe = 1'b1;
              bus.pc_ie = 1'b1;
            end
            OP_JC: begin
              bus.ir_oe = bus.carry;
              bus.pc_ie = bus.carry;
            end
            OP_JZ: begin
              bus.ir_oe = bus.zero;
              bus.pc_ie = bus.zero;
            end
            OP_OUT: begin
              bus.a_oe   = 1'b1;
              bus.out_ie = 1'b1;
            end
            OP_HLT:  bus.hlt = 1'b1;
            default: bus.hlt = 1'b0;
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin
              bus.ram_oe = 1'b1;
              bus.a_ie   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ram_oe  = 1'b1;
              bus.b_ie    = 1'b1;
              bus.alu_sub = (bus.opcode == OP_SUB);
            end
            OP_STA: begin
              bus.a_oe   = 1'b1;
              bus.ram_ie = 1'b1;
            end
            default: bus.hlt = 1'b0;
          endcase
        end
        T4: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.alu_oe   = 1'b1;
            bus.a_ie     = 1'b1;
            bus.flags_ie = 1'b1;
            bus.alu_sub  = (bus.opcode == OP_SUB);
          end
        end
        default: bus.hlt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer_module.sv
// Scoreboard bench for control_sequencer_module: each instruction pushes its expected
// per-cycle (tstate, control word) trace, which is popped and compared cycle by cycle.
module tb_control_sequencer_module;

  localparam logic [15:0] PC_OE    = 16'h8000;
  localparam logic [15:0] PC_IE    = 16'h4000;
  localparam logic [15:0] PC_STEP  = 16'h2000;
  localparam logic [15:0] MAR_IE   = 16'h1000;
  localparam logic [15:0] RAM_OE   = 16'h0800;
  localparam logic [15:0] RAM_IE   = 16'h0400;
  localparam logic [15:0] IR_IE    = 16'h0200;
  localparam logic [15:0] IR_OE    = 16'h0100;
  localparam logic [15:0] A_IE     = 16'h0080;
  localparam logic [15:0] A_OE     = 16'h0040;
  localparam logic [15:0] B_IE     = 16'h0020;
  localparam logic [15:0] ALU_OE   = 16'h0010;
  localparam logic [15:0] ALU_SUB  = 16'h0008;
  localparam logic [15:0] FLAGS_IE = 16'h0004;
  localparam logic [15:0] OUT_IE   = 16'h0002;
  localparam logic [15:0] HLT      = 16'h0001;

  typedef struct packed {
    logic [2:0]  ts;
    logic [15:0] w;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];

  control_sequencer_module_if bus ();

  control_sequencer_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] act_w;
  logic [4:0]  oe_vec;
  assign act_w = {bus.pc_oe, bus.pc_ie, bus.pc_step, bus.mar_ie, bus.ram_oe, bus.ram_ie,
                  bus.ir_ie, bus.ir_oe, bus.a_ie, bus.a_oe, bus.b_ie, bus.alu_oe,
                  bus.alu_sub, bus.flags_ie, bus.out_ie, bus.hlt};
  assign oe_vec = {bus.pc_oe, bus.ram_oe, bus.ir_oe, bus.a_oe, bus.alu_oe};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input logic [2:0] ts, input logic [15:0] w);
    exp_q.push_back({ts, w});
  endfunction

  // Expected trace of one whole instruction, fetch included.
  function automatic void push_instr(input logic [3:0] op, input logic c, input logic z);
    logic [15:0] s;
    s = (op == 4'b0011) ? ALU_SUB : 16'h0000;
    push(3'd0, PC_OE | MAR_IE);
    push(3'd1, RAM_OE | IR_IE | PC_STEP);
    case (op)
      4'b0001: begin
        push(3'd2, IR_OE | MAR_IE);
        push(3'd3, RAM_OE | A_IE);
      end
      4'b0010, 4'b0011: begin
        push(3'd2, IR_OE | MAR_IE);
        push(3'd3, RAM_OE | B_IE | s);
        push(3'd4, ALU_OE | A_IE | FLAGS_IE | s);
      end
      4'b0100: begin
        push(3'd2, IR_OE | MAR_IE);
        push(3'd3, A_OE | RAM_IE);
      end
      4'b0101: push(3'd2, IR_OE | A_IE);
      4'b0110: push(3'd2, IR_OE | PC_IE);
      4'b0111: push(3'd2, c ? (IR_OE | PC_IE) : 16'h0000);
      4'b1000: push(3'd2, z ? (IR_OE | PC_IE) : 16'h0000);
      4'b1110: push(3'd2, A_OE | OUT_IE);
      4'b1111: push(3'd2, HLT);
      default: push(3'd2, 16'h0000);
    endcase
  endfunction

  // Entered and left at 2 time units after a rising edge.
  task automatic drain(input string name);
    exp_t e;
    while (exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.tstate !== e.ts || act_w !== e.w) begin
        bad++;
        $display("[TB] FAIL %s: got ts=%0d word=%h, expected ts=%0d word=%h",
                 name, bus.tstate, act_w, e.ts, e.w);
      end
      total++;
      if ($countones(oe_vec) > 1 || (bus.pc_step & bus.pc_ie) !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s_invariant: got oe=%b pc_step=%b pc_ie=%b, expected <=1 oe and no step+load",
                 name, oe_vec, bus.pc_step, bus.pc_ie);
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic run_instr(input string name, input logic [3:0] op, input logic c, input logic z);
    bus.opcode = op;
    bus.carry  = c;
    bus.zero   = z;
    push_instr(op, c, z);
    drain(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.opcode = 4'b0000;
    bus.carry  = 1'b0;
    bus.zero   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #3;
      total++;
      if (act_w !== 16'h0000 || bus.tstate !== 3'd0) begin
        bad++;
        $display("[TB] FAIL reset_hold: got ts=%0d word=%h, expected ts=0 word=0000", bus.tstate, act_w);
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    run_instr("reset_fetch", 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_alu();
    run_instr("add", 4'b0010, 1'b0, 1'b0);
    run_instr("sub", 4'b0011, 1'b1, 1'b1);
    run_instr("lda", 4'b0001, 1'b0, 1'b0);
    run_instr("sta", 4'b0100, 1'b0, 1'b0);
  endtask

  task automatic test_jumps();
    run_instr("jc_no", 4'b0111, 1'b0, 1'b1);
    run_instr("jc_yes", 4'b0111, 1'b1, 1'b0);
    run_instr("jz_no", 4'b1000, 1'b1, 1'b0);
    run_instr("jz_yes", 4'b1000, 1'b0, 1'b1);
    run_instr("jmp", 4'b0110, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_instr("ldi", 4'b0101, 1'b0, 1'b0);
    run_instr("out", 4'b1110, 1'b0, 1'b0);
    run_instr("add_b2b", 4'b0010, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    bus.opcode = 4'b0001;
    push_instr(4'b0001, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    drain("lda_pre_reset");
    #1;
    total++;
    if (bus.tstate !== 3'd3 || act_w !== (RAM_OE | A_IE)) begin
      bad++;
      $display("[TB] FAIL lda_t3: got ts=%0d word=%h, expected ts=3 word=%h", bus.tstate, act_w, RAM_OE | A_IE);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.tstate !== 3'd0 || act_w !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL mid_reset_async: got ts=%0d word=%h, expected ts=0 word=0000", bus.tstate, act_w);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    run_instr("lda_restart", 4'b0001, 1'b0, 1'b0);
  endtask

  task automatic test_sweep();
    logic c;
    logic z;
    for (int op = 0; op < 15; op++) begin
      c = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      run_instr($sformatf("sweep_op%0d", op), 4'(op), c, z);
    end
  endtask

  task automatic test_halt();
    bus.opcode = 4'b1111;
    push_instr(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) push(3'd2, HLT);
    drain("halt");
    rst = 1'b1;
    #1;
    total++;
    if (act_w !== 16'h0000 || bus.tstate !== 3'd0) begin
      bad++;
      $display("[TB] FAIL halt_reset: got ts=%0d word=%h, expected ts=0 word=0000", bus.tstate, act_w);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    run_instr("after_halt", 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_alu();
    test_jumps();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
